frm_timing_rx: RTL and testbench
================================

FRM_TIMING_RX -- requirements
Module: frm_timing_rx

Interface
REQ-001 SHALL have parameter EXP_WIDTH, 1920, expected active pixels per line.
REQ-002 SHALL have parameter EXP_HEIGHT, 1080, expected active lines per frame.
REQ-003 SHALL have port pixclk  input  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous assert, active-high.
REQ-005 SHALL have port en  input  1  receive enable.
REQ-006 SHALL have port lval  input  1  line valid from frame source.
REQ-007 SHALL have port fval  input  1  frame valid from frame source.
REQ-008 SHALL have port pix_vld  output  1  registered active-pixel qualifier.
REQ-009 SHALL have ports pix_x, pix_y  output  12 each  coordinates of the qualified pixel.
REQ-010 SHALL have ports sof, eof  output  1 each  single-cycle start/end-of-frame pulses.
REQ-011 SHALL have ports meas_width, meas_height  output  12 each  last measured line width / frame height.
REQ-012 SHALL have port meas_vld  output  1  single-cycle pulse when meas_* update at frame end.
REQ-013 SHALL have port locked  output  1  high while state is FRAME or ARMED after one complete frame.
REQ-014 SHALL have ports err_width, err_height  output  1 each  sticky mismatch flags; err_clr  input  1  clears them.

Function
REQ-015 SHALL register lval/fval each enabled cycle into lval_d/fval_d; edges = current sample vs. _d.
REQ-016 SHALL implement states UNLOCK -> ARMED (fval sample 0) -> FRAME (fval rising) -> ARMED (fval falling).
REQ-017 SHALL assert pix_vld one cycle after a sample with en=1, lval=1, fval=1, state FRAME; else 0.
REQ-018 SHALL output pix_x = pixel index from 0 at each lval rising within FRAME; x counter cleared when lval sampled 0.
REQ-019 SHALL output pix_y = line index from 0 at frame start; increments on each lval falling edge while fval sampled 1.
REQ-020 SHALL pulse sof on the cycle following the ARMED->FRAME transition, eof with meas_vld on the cycle following FRAME->ARMED.
REQ-021 SHALL at fval falling latch meas_height = completed lines + 1 if lval_d=1 (line truncated by simultaneous fall counts).
REQ-022 SHALL latch meas_width = line pixel count at each lval falling edge (or truncation by fval) within FRAME.
REQ-023 SHALL saturate x/y counters at 4095; no wrap.
REQ-024 SHALL ignore lval activity outside FRAME (no pix_vld, no counting).
REQ-025 SHALL, with en=0, hold all state, counters and _d registers; pix_vld, sof, eof, meas_vld = 0.
REQ-026 SHALL set locked at first eof; clear only on reset.
REQ-027 SHALL give err_clr priority below a same-cycle new error (set wins).

Reset
REQ-028 SHALL on rst drive all outputs 0, counters 0, lval_d/fval_d 0, state UNLOCK.
REQ-029 SHALL, after reset released mid-frame, discard that frame: no pix_vld until fval seen 0 then rising.

Configuration
REQ-030 SHALL, with macro FRM_TIMING_RX_CHK_EN defined, set err_width when any line width != EXP_WIDTH and err_height when meas_height != EXP_HEIGHT at frame end.
REQ-031 SHALL, without FRM_TIMING_RX_CHK_EN, tie err_width/err_height to 0 and remove compare logic; err_clr unused.

Verification (EXP_WIDTH=8, EXP_HEIGHT=4 bench build)
REQ-032 SHALL cover: nominal frames, line blank 3, frame blank 2, 8x4 active -> pix_vld 32 cycles/frame, pix_x 0..7, pix_y 0..3, meas 8/4, meas_vld once, errs 0.
REQ-033 SHALL cover: reset released mid-frame at line 2 -> no pix_vld/sof until next fval rise; locked after that frame's eof.
REQ-034 SHALL cover: one line of 7 pixels, CHK_EN defined -> err_width=1 at that line end, stays 1 until err_clr; meas_width=7.
REQ-035 SHALL cover: fval and lval fall same cycle on line 3 -> meas_height=4, err_height=0.
REQ-036 SHALL cover: en low for 5 cycles mid-line -> pix_x resumes without skip; meas_width=8.
REQ-037 SHALL cover: lval held 5000 cycles -> pix_x saturates 4095; meas_width=4095, err_width=1.

Source files
------------

// File: rtl/frm_timing_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : frm_timing_rx_if
//  Brief    : Frame-source side (lval/fval) and qualified-pixel side
//             (pix_vld, coordinates, sof/eof) of the frame timing receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface frm_timing_rx_if;
    logic        lval;
    logic        fval;
    logic        pix_vld;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        sof;
    logic        eof;

    // Frame source / downstream consumer view
    modport master (
        output lval, fval,
        input  pix_vld, pix_x, pix_y, sof, eof
    );

    // Receiver view
    modport slave (
        input  lval, fval,
        output pix_vld, pix_x, pix_y, sof, eof
    );
endinterface
`default_nettype wire

// File: rtl/frm_timing_rx.sv
`default_nettype none
// ============================================================================
//  Module   : frm_timing_rx
//  Brief    : Line/frame-valid timing receiver. Locks onto the frame source,
//             qualifies active pixels with x/y coordinates, measures line
//             width and frame height, and optionally flags size mismatches.
//  Options  : FRM_TIMING_RX_CHK_EN - enables the width/height compare and the
//             sticky err_width/err_height flags (tied low otherwise).
//  Revision : 1.0  initial release
// ============================================================================
module frm_timing_rx #(
    parameter int EXP_WIDTH  = 1920,
    parameter int EXP_HEIGHT = 1080
) (
    input  wire logic         pixclk,
    input  wire logic         rst,
    input  wire logic         en,
    frm_timing_rx_if.slave    bus,
    output logic [11:0]       meas_width,
    output logic [11:0]       meas_height,
    output logic              meas_vld,
    output logic              locked,
    output logic              err_width,
    output logic              err_height,
    input  wire logic         err_clr
);

    localparam logic [1:0]  ST_UNLOCK = 2'd0;
    localparam logic [1:0]  ST_ARMED  = 2'd1;
    localparam logic [1:0]  ST_FRAME  = 2'd2;
    localparam logic [11:0] CNT_MAX   = 12'hFFF;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        lval_d;
    logic        fval_d;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;

    logic        frame_start;
    logic        frame_end;
    logic        pix_take;
    logic        line_end;
    logic        line_inc;
    logic [11:0] height_now;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

    // Edges compare the current sample against the previous enabled sample
    wire fval_rise = bus.fval & ~fval_d;
    wire fval_fall = ~bus.fval & fval_d;
    wire lval_fall = ~bus.lval & lval_d;

    // State register; advances only on enabled cycles
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) state <= ST_UNLOCK;
        else if (en) state <= state_nxt;
    end

    // Next state: a frame already in progress at lock time is skipped by
    // requiring fval low before arming for the next rising edge
    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCK: if (!bus.fval) state_nxt = ST_ARMED;
            ST_ARMED:  if (fval_rise) state_nxt = ST_FRAME;
            ST_FRAME:  if (fval_fall) state_nxt = ST_ARMED;
            default:   state_nxt = ST_UNLOCK;
        endcase
    end

    // Decoded per-cycle events; a line truncated by fval falling still ends
    always_comb begin
        frame_start = en && (state == ST_ARMED) && fval_rise;
        frame_end   = en && (state == ST_FRAME) && fval_fall;
        pix_take    = en && (state == ST_FRAME) && bus.lval && bus.fval;
        line_end    = en && (state == ST_FRAME) && lval_d && (!bus.lval || !bus.fval);
        line_inc    = en && (state == ST_FRAME) && lval_fall && bus.fval;
        height_now  = lval_d ? sat_inc(y_cnt) : y_cnt;
    end

    // Sample registers, counters, pixel qualifier, pulses and measurements
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            lval_d      <= 1'b0;
            fval_d      <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            bus.pix_vld <= 1'b0;
            bus.pix_x   <= '0;
            bus.pix_y   <= '0;
            bus.sof     <= 1'b0;
            bus.eof     <= 1'b0;
            meas_vld    <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            locked      <= 1'b0;
        end else begin
            bus.pix_vld <= pix_take;
            bus.sof     <= frame_start;
            bus.eof     <= frame_end;
            meas_vld    <= frame_end;
            if (en) begin
                lval_d <= bus.lval;
                fval_d <= bus.fval;
            end
            if (pix_take) begin
                bus.pix_x <= x_cnt;
                bus.pix_y <= y_cnt;
                x_cnt     <= sat_inc(x_cnt);
            end else if (en) begin
                x_cnt <= '0;
            end
            if (frame_start)   y_cnt <= '0;
            else if (line_inc) y_cnt <= sat_inc(y_cnt);
            if (line_end) meas_width <= x_cnt;
            if (frame_end) begin
                meas_height <= height_now;
                locked      <= 1'b1;
            end
        end
    end

`ifdef FRM_TIMING_RX_CHK_EN
    localparam logic [11:0] EXP_W = 12'(EXP_WIDTH);
    localparam logic [11:0] EXP_H = 12'(EXP_HEIGHT);

    // Sticky mismatch flags; a new mismatch wins over a same-cycle clear
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            err_width  <= 1'b0;
            err_height <= 1'b0;
        end else begin
            if (line_end && (x_cnt != EXP_W)) err_width <= 1'b1;
            else if (err_clr)                 err_width <= 1'b0;
            if (frame_end && (height_now != EXP_H)) err_height <= 1'b1;
            else if (err_clr)                       err_height <= 1'b0;
        end
    end
`else
    logic [24:0] unused_cfg;
    assign unused_cfg = {err_clr, 12'(EXP_WIDTH), 12'(EXP_HEIGHT)};
    assign err_width  = 1'b0;
    assign err_height = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frm_timing_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frm_timing_rx
//  Brief    : Self-checking bench for frm_timing_rx with an 8x4 active frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frm_timing_rx;

`ifdef FRM_TIMING_RX_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        pixclk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        err_clr = 1'b0;
    logic [11:0] meas_width, meas_height;
    logic        meas_vld, locked, err_width, err_height;

    frm_timing_rx_if bus_if ();

    frm_timing_rx #(.EXP_WIDTH(8), .EXP_HEIGHT(4)) dut (
        .pixclk      (pixclk),
        .rst         (rst),
        .en          (en),
        .bus         (bus_if),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .meas_vld    (meas_vld),
        .locked      (locked),
        .err_width   (err_width),
        .err_height  (err_height),
        .err_clr     (err_clr)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        bit en, lval, fval;
        bit vld, sof, eof, mvld, lock;
        int x, y;
        bit chkw, chkh;
        int mw, mh;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   exp_lock = 1'b0;
    bit   exp_ew = 1'b0;
    bit   exp_eh = 1'b0;

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic drive(input bit e, input bit l, input bit f);
        en = e;
        bus_if.lval = l;
        bus_if.fval = f;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input bit e, input bit l, input bit f, input bit lk);
        vec_t v;
        v = '{default: 0};
        v.en = e; v.lval = l; v.fval = f; v.lock = lk;
        return v;
    endfunction

    function automatic int sat(input int p);
        return (p > 4095) ? 4095 : p;
    endfunction

    // One line of w pixels at line index y; live selects qualified or ignored
    task automatic send_line(input int w, input int y, input bit live);
        for (int p = 0; p < w; p++) begin
            drive(1, 1, 1);
            tick();
            if (live) chk("pixel", {bus_if.pix_vld, bus_if.sof, bus_if.pix_x, bus_if.pix_y},
                          {1'b1, 1'b0, 12'(sat(p)), 12'(y)});
            else      chk("ignored_pixel", {bus_if.pix_vld, bus_if.sof}, 2'b00);
        end
    endtask

    // Line blank of n cycles; the first cycle carries the width measurement
    task automatic gap(input int n, input int mw);
        for (int g = 0; g < n; g++) begin
            drive(1, 0, 1);
            tick();
            if (g == 0) chk("line_end", {bus_if.pix_vld, err_width, meas_width},
                            {1'b0, exp_ew, 12'(mw)});
        end
    endtask

    task automatic frame_start();
        drive(1, 0, 1);
        tick();
        chk("sof", {bus_if.sof, bus_if.pix_vld}, 2'b10);
    endtask

    // fval falls, then one more blank cycle
    task automatic frame_end(input bit live, input int mh);
        drive(1, 0, 0);
        tick();
        if (live) begin
            exp_lock = 1'b1;
            chk("eof", {bus_if.eof, meas_vld, locked, err_width, err_height, meas_height},
                {1'b1, 1'b1, 1'b1, exp_ew, exp_eh, 12'(mh)});
        end else begin
            chk("no_eof", {bus_if.eof, meas_vld, locked}, {2'b00, exp_lock});
        end
        tick();
        chk("eof_pulse", {bus_if.eof, meas_vld, locked}, {2'b00, exp_lock});
    endtask

    task automatic nom_lines(input int first);
        for (int l = first; l < 4; l++) begin
            send_line(8, l, 1);
            gap(3, 8);
        end
    endtask

    initial begin
        vec_t v;
        drive(0, 0, 0);

        // ---- table: blank, then two nominal 8x4 frames ----
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0));
        for (int fr = 0; fr < 2; fr++) begin
            v = mk(1, 0, 1, fr > 0); v.sof = 1; tbl.push_back(v);
            for (int l = 0; l < 4; l++) begin
                for (int p = 0; p < 8; p++) begin
                    v = mk(1, 1, 1, fr > 0); v.vld = 1; v.x = p; v.y = l; tbl.push_back(v);
                end
                for (int g = 0; g < 3; g++) begin
                    v = mk(1, 0, 1, fr > 0);
                    if (g == 0) begin v.chkw = 1; v.mw = 8; end
                    tbl.push_back(v);
                end
            end
            v = mk(1, 0, 0, 1); v.eof = 1; v.mvld = 1; v.chkw = 1; v.mw = 8;
            v.chkh = 1; v.mh = 4; tbl.push_back(v);
            tbl.push_back(mk(1, 0, 0, 1));
        end

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_flags", {bus_if.pix_vld, bus_if.sof, bus_if.eof, meas_vld, locked}, 5'b0);
        chk("rst_coords", {bus_if.pix_x, bus_if.pix_y}, 24'd0);
        chk("rst_meas", {meas_width, meas_height}, 24'd0);
        chk("rst_err", {err_width, err_height}, 2'b00);
        rst = 1'b0;

        // ---- apply table ----
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].lval, tbl[i].fval);
            tick();
            chk($sformatf("row%0d_flags", i),
                {bus_if.pix_vld, bus_if.sof, bus_if.eof, meas_vld, locked, err_width, err_height},
                {tbl[i].vld, tbl[i].sof, tbl[i].eof, tbl[i].mvld, tbl[i].lock, 2'b00});
            if (tbl[i].vld)
                chk($sformatf("row%0d_xy", i), {bus_if.pix_x, bus_if.pix_y},
                    {12'(tbl[i].x), 12'(tbl[i].y)});
            if (tbl[i].chkw) chk($sformatf("row%0d_mw", i), meas_width, tbl[i].mw);
            if (tbl[i].chkh) chk($sformatf("row%0d_mh", i), meas_height, tbl[i].mh);
        end
        exp_lock = 1'b1;

        // ---- short line of 7 pixels, sticky error, then clear ----
        frame_start();
        send_line(8, 0, 1); gap(3, 8);
        send_line(7, 1, 1);
        exp_ew = CHK;
        gap(3, 7);
        send_line(8, 2, 1); gap(3, 8);
        send_line(8, 3, 1); gap(3, 8);
        frame_end(1, 4);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        exp_ew = 1'b0;
        chk("err_clr", {err_width, err_height}, 2'b00);
        tick();

        // ---- lval and fval fall together on line 3 ----
        frame_start();
        for (int l = 0; l < 3; l++) begin send_line(8, l, 1); gap(3, 8); end
        send_line(8, 3, 1);
        drive(1, 0, 0);
        tick();
        chk("trunc_end", {bus_if.eof, meas_vld, err_width, err_height, meas_width, meas_height},
            {4'b1100, 12'd8, 12'd4});
        tick();

        // ---- en low for 5 cycles mid-line ----
        frame_start();
        for (int p = 0; p < 4; p++) begin
            drive(1, 1, 1); tick();
            chk("pre_stall", {bus_if.pix_vld, bus_if.pix_x}, {1'b1, 12'(p)});
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1); tick();
            chk("stall", {bus_if.pix_vld, bus_if.pix_x}, {1'b0, 12'd3});
        end
        for (int p = 4; p < 8; p++) begin
            drive(1, 1, 1); tick();
            chk("post_stall", {bus_if.pix_vld, bus_if.pix_x, bus_if.pix_y}, {1'b1, 12'(p), 12'd0});
        end
        gap(3, 8);
        nom_lines(1);
        frame_end(1, 4);

        // ---- lval held 5000 cycles: saturation; set wins over clear ----
        frame_start();
        send_line(5000, 0, 1);
        err_clr = 1'b1;
        drive(1, 0, 1); tick();
        err_clr = 1'b0;
        exp_ew = CHK;
        chk("sat_end", {err_width, meas_width}, {exp_ew, 12'd4095});
        drive(1, 0, 1); tick();
        exp_eh = CHK;
        frame_end(1, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        exp_ew = 1'b0; exp_eh = 1'b0;
        chk("err_clr2", {err_width, err_height}, 2'b00);

        // ---- reset released mid-frame at line 2 ----
        frame_start();
        send_line(8, 0, 1); gap(3, 8);
        send_line(8, 1, 1); gap(3, 8);
        send_line(3, 2, 1);
        rst = 1'b1;
        exp_lock = 1'b0;
        tick();
        chk("mid_rst", {bus_if.pix_vld, locked, meas_width, meas_height, bus_if.pix_x},
            {2'b00, 12'd0, 12'd0, 12'd0});
        tick();
        rst = 1'b0;
        send_line(5, 2, 0); gap(3, 0);
        send_line(8, 3, 0); gap(3, 0);
        frame_end(0, 0);
        frame_start();
        nom_lines(0);
        frame_end(1, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
